// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-memory stage that sits behind the single-cycle decode/execute stage.
// It accepts one load/store request at a time and drives a word-addressed DMEM
// bus with a req/ack handshake. Loads come back aligned and sign- or
// zero-extended. A stall output holds the core's PC and IR while a bus
// transaction is outstanding.
//
// Optional feature (compile-time macro LSU_TIMEOUT_EN):
//   When defined, a bus transaction that sees no mem_ack_i for TIMEOUT_CYCLES
//   cycles is aborted. The abort drops the request and pulses ls_fault_o.
//   When undefined, the BUS state waits for an ack indefinitely.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous, active-low reset
//   ls_valid_i     request strobe from the execute stage
//   ls_we_i        1 = store, 0 = load
//   ls_size_i      00 byte, 01 half, 10 word (11 illegal)
//   ls_unsigned_i  zero-extend loads (LBU/LHU)
//   ls_addr_i      byte address
//   ls_wdata_i     store data (rs2)
//   ls_rdata_o     formatted load data; holds until the next load completes
//   ls_done_o      one-cycle completion pulse
//   ls_fault_o     one-cycle pulse on misalign, illegal size or timeout
//   ls_busy_o      stall request to the core
//   mem_req_o      bus request
//   mem_we_o       bus write
//   mem_addr_o     word-aligned bus address
//   mem_wdata_o    lane-replicated store data
//   mem_be_o       byte write enables (all zero for loads)
//   mem_rdata_i    bus read data
//   mem_ack_i      bus acknowledge
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ls_valid_i,
    input  logic        ls_we_i,
    input  logic [1:0]  ls_size_i,
    input  logic        ls_unsigned_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic [31:0] ls_rdata_o,
    output logic        ls_done_o,
    output logic        ls_fault_o,
    output logic        ls_busy_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_e      state_q, state_d;

    // Request attributes captured at accept time, used when the ack arrives.
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;

    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        busy_q, busy_d;

    logic        req_q, req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

`ifdef LSU_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
`endif

    // -------------------------------------------------------------------------
    // Request decode (combinational on the incoming request)
    // -------------------------------------------------------------------------
    logic        req_illegal;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    always_comb begin
        req_illegal = 1'b0;
        req_be      = 4'b0000;
        req_wdata   = ls_wdata_i;
        unique case (ls_size_i)
            SIZE_BYTE: begin
                req_be    = 4'b0001 << ls_addr_i[1:0];
                req_wdata = {4{ls_wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                req_illegal = ls_addr_i[0];
                req_be      = 4'b0011 << ls_addr_i[1:0];
                req_wdata   = {2{ls_wdata_i[15:0]}};
            end
            SIZE_WORD: begin
                req_illegal = (ls_addr_i[1:0] != 2'b00);
                req_be      = 4'b1111;
            end
            default: begin
                req_illegal = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load formatting from the captured size/offset/sign attributes
    // -------------------------------------------------------------------------
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_fmt;

    always_comb begin
        load_byte = mem_rdata_i[{off_q, 3'b000} +: 8];
        load_half = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
        unique case (size_q)
            SIZE_BYTE: load_fmt = {{24{load_byte[7] & ~uns_q}}, load_byte};
            SIZE_HALF: load_fmt = {{16{load_half[15] & ~uns_q}}, load_half};
            default:   load_fmt = mem_rdata_i;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal is given a default before the case statement. A path
    // that leaves a combinational output unassigned would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        busy_d   = busy_q;
        req_d    = req_q;
        mem_we_d = mem_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (ls_valid_i) begin
                    we_d   = ls_we_i;
                    size_d = ls_size_i;
                    uns_d  = ls_unsigned_i;
                    off_d  = ls_addr_i[1:0];
                    if (req_illegal) begin
                        // Bad requests never reach the bus; report and stay idle.
                        fault_d = 1'b1;
                    end else begin
                        state_d  = BUS;
                        req_d    = 1'b1;
                        busy_d   = 1'b1;
                        mem_we_d = ls_we_i;
                        addr_d   = {ls_addr_i[31:2], 2'b00};
                        wdata_d  = req_wdata;
                        // Byte enables qualify writes only; loads fetch the whole word.
                        be_d     = ls_we_i ? req_be : 4'b0000;
`ifdef LSU_TIMEOUT_EN
                        cnt_d    = 8'd0;
`endif
                    end
                end
            end

            BUS: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = load_fmt;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    // The limit is checked only when no ack is present, so an
                    // ack arriving in the last allowed cycle still completes.
                    state_d = IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then updates from values sampled before the edge, whatever order the
    // statements appear in.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            rdata_q  <= 32'd0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            mem_we_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
            req_q    <= req_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // All outputs are driven straight from registers.
    assign ls_rdata_o  = rdata_q;
    assign ls_done_o   = done_q;
    assign ls_fault_o  = fault_q;
    assign ls_busy_o   = busy_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory stage downstream of the single-cycle decode/execute stage.
- Takes one load/store request per transaction from the core: ALU-computed address, rs2 store data, and size/sign from funct3.
- Drives a word-addressed DMEM bus with byte enables and a req/ack handshake. Returns aligned, sign- or zero-extended load data plus a stall signal that holds the core's PC and IR.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in BUS state without mem_ack_i before the transaction aborts (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- ls_valid_i  in  1  request strobe from execute stage
- ls_we_i  in  1  1 = store, 0 = load
- ls_size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal
- ls_unsigned_i  in  1  zero-extend load (LBU/LHU)
- ls_addr_i  in  32  byte address
- ls_wdata_i  in  32  store data (rs2)
- ls_rdata_o  out  32  formatted load data
- ls_done_o  out  1  one-cycle completion pulse
- ls_fault_o  out  1  one-cycle pulse on misalign, illegal size or timeout
- ls_busy_o  out  1  stall to core
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata_o  out  32  lane-replicated store data
- mem_be_o  out  4  byte enables
- mem_rdata_i  in  32  bus read data
- mem_ack_i  in  1  bus acknowledge

Behaviour:
- Reset: rst_i low asynchronously clears all state; FSM goes to IDLE.
  - All outputs reset to 0: ls_rdata_o, ls_done_o, ls_fault_o, ls_busy_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o.
  - Reset mid-transaction drops mem_req_o immediately and produces no done/fault pulse.
- FSM states: IDLE, BUS.
- IDLE, ls_valid_i=1:
  - Latch we, size, unsigned, addr[1:0] and data.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0) or size=11: next cycle ls_fault_o=1 for one cycle, no bus request, stay IDLE.
  - Otherwise go to BUS. Next cycle mem_req_o=1 and ls_busy_o=1 (both registered).
- IDLE, ls_valid_i=0: no action.
- BUS: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o are held stable until a cycle with mem_ack_i=1.
  - On that clock edge: mem_req_o=0, ls_busy_o=0, ls_done_o=1 for one cycle, return to IDLE.
  - Loads: ls_rdata_o is registered on the ack edge and holds until the next load completes.
  - Minimum latency (ack in first req cycle): valid at cycle 0, req at cycle 1, done at cycle 2.
- ls_valid_i while in BUS is ignored (the core is stalled by ls_busy_o). A new request is accepted in the same cycle ls_done_o is high (state is already IDLE).
- mem_ack_i in IDLE is ignored.
- Byte enables:
  - byte: be = 4'b0001 << addr[1:0]
  - half: be = 4'b0011 << addr[1:0]
  - word: be = 4'b1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load formatting:
  - byte lane = rdata[8*addr[1:0] +: 8]; half lane = rdata[16*addr[1] +: 16].
  - Sign-extend the lane unless ls_unsigned_i=1, in which case zero-extend.
- Stores: ls_rdata_o is unchanged.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack, the next edge drops mem_req_o, pulses ls_fault_o, leaves ls_done_o=0 and returns to IDLE.
  - An ack in the same cycle as the limit wins: the transaction completes normally.
- LSU_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; ls_fault_o reports only misalign and illegal size.

Test Plan:
- LB, addr 0x103, rdata 0x80FF_1234, ack in first req cycle -> mem_addr_o=0x100, be=0000 (load), ls_rdata_o=0xFFFF_FF80, ls_done_o at cycle 2.
- LHU, addr 0x202, rdata 0x9ABC_5678 -> ls_rdata_o=0x0000_9ABC.
- SB, addr 0x301, wdata 0x0000_00A5 -> mem_we_o=1, be=0010, mem_wdata_o=0xA5A5_A5A5; ack delayed 3 cycles -> ls_busy_o high 4 cycles, single done pulse.
- LW, addr 0x402 -> ls_fault_o pulse, mem_req_o never asserted; SH, addr 0x3 -> fault.
- Reset low while in BUS -> mem_req_o=0 asynchronously, no done or fault; after release, new SW completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> req held 16 cycles, then fault pulse and return to IDLE; ack in cycle 16 -> normal done.
